// File: rtl/prio_arbiter_if.sv
// rtl/prio_arbiter_if.sv - request/grant bundle between requesters, arbiter and grant consumer
interface prio_arbiter_if #(
  parameter int N = 8
) ();
  localparam int W = $clog2(N);

  logic [N-1:0] req;
  logic         gnt_ready;
  logic         gnt_valid;
  logic [W-1:0] gnt_idx;
  logic [N-1:0] gnt_onehot;

  modport master (
    output req, gnt_ready,
    input  gnt_valid, gnt_idx, gnt_onehot
  );

  modport slave (
    input  req, gnt_ready,
    output gnt_valid, gnt_idx, gnt_onehot
  );
endinterface

// File: rtl/prio_arbiter.sv
// rtl/prio_arbiter.sv - registered fixed/round-robin priority arbiter with held grant handshake
module prio_arbiter #(
  parameter int N  = 8,
  parameter int RR = 0
) (
  input  logic         clk,
  input  logic         rst,
  prio_arbiter_if.slave bus
);
  localparam int W = $clog2(N);
  localparam logic [N-1:0] ONE_HOT_0 = N'(1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t       r_state;
  logic [W-1:0] r_ptr;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_onehot;

  state_t       w_state_nxt;
  logic [W-1:0] w_ptr_nxt;
  logic [W-1:0] w_idx_nxt;
  logic [N-1:0] w_onehot_nxt;
  logic         w_accept;
  logic [N-1:0] w_search;
  logic         w_found;
  logic [W-1:0] w_win;
  int           w_pos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= W'(N - 1);
      r_idx    <= '0;
      r_onehot <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_idx    <= w_idx_nxt;
      r_onehot <= w_onehot_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_idx_nxt    = r_idx;
    w_onehot_nxt = r_onehot;
    w_found      = 1'b0;
    w_win        = '0;
    w_pos        = 0;

    w_accept = (r_state == GRANT) && bus.gnt_ready;

    // Pointer moves past the accepted index before the back-to-back search below.
    if ((RR != 0) && w_accept) begin
      w_ptr_nxt = (r_idx == '0) ? W'(N - 1) : (r_idx - W'(1));
    end

    // The requester just served still shows its bit this cycle, so it is masked out.
    w_search = (r_state == IDLE) ? bus.req : (bus.req & ~r_onehot);

    for (int k = 0; k < N; k++) begin
      w_pos = (int'(w_ptr_nxt) >= k) ? (int'(w_ptr_nxt) - k) : (int'(w_ptr_nxt) + N - k);
      if (!w_found && w_search[w_pos[W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_pos[W-1:0];
      end
    end

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt  = GRANT;
          w_idx_nxt    = w_win;
          w_onehot_nxt = ONE_HOT_0 << w_win;
        end
      end
      GRANT: begin
        if (w_accept) begin
          if (w_found) begin
            w_idx_nxt    = w_win;
            w_onehot_nxt = ONE_HOT_0 << w_win;
          end else begin
            w_state_nxt  = IDLE;
            w_idx_nxt    = '0;
            w_onehot_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_idx_nxt    = '0;
        w_onehot_nxt = '0;
      end
    endcase
  end

  assign bus.gnt_valid  = (r_state == GRANT);
  assign bus.gnt_idx    = r_idx;
  assign bus.gnt_onehot = r_onehot;
endmodule

// File: tb/tb_prio_arbiter.sv
// tb/tb_prio_arbiter.sv - random and directed checks of three arbiter configurations against a search model
module tb_prio_arbiter;
  logic clk;
  logic rst;

  logic [7:0] r_req [3];
  logic       r_rdy [3];

  int nn  [3] = '{8, 8, 5};
  int rrs [3] = '{0, 1, 1};

  int m_valid [3];
  int m_idx   [3];
  int m_ptr   [3];

  int n_checks = 0;
  int n_pass   = 0;

  prio_arbiter_if #(.N(8)) if0 ();
  prio_arbiter_if #(.N(8)) if1 ();
  prio_arbiter_if #(.N(5)) if2 ();

  assign if0.req       = r_req[0];
  assign if1.req       = r_req[1];
  assign if2.req       = r_req[2][4:0];
  assign if0.gnt_ready = r_rdy[0];
  assign if1.gnt_ready = r_rdy[1];
  assign if2.gnt_ready = r_rdy[2];

  prio_arbiter #(.N(8), .RR(0)) u_fix8 (.clk(clk), .rst(rst), .bus(if0));
  prio_arbiter #(.N(8), .RR(1)) u_rr8  (.clk(clk), .rst(rst), .bus(if1));
  prio_arbiter #(.N(5), .RR(1)) u_rr5  (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // First set bit walking downward from ptr, wrapping mod n; -1 when none.
  function automatic int winner(input int vec, input int ptr, input int n);
    for (int k = 0; k < n; k++) begin
      int p;
      p = (ptr - k + n) % n;
      if (vec[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 0;
      m_idx[i]   = 0;
      m_ptr[i]   = nn[i] - 1;
    end
  endtask

  task automatic model_edge(input int i);
    int rq;
    int w;
    rq = int'(r_req[i]) & ((1 << nn[i]) - 1);
    if (m_valid[i] == 0) begin
      w = winner(rq, m_ptr[i], nn[i]);
      if (w >= 0) begin
        m_valid[i] = 1;
        m_idx[i]   = w;
      end
    end else if (r_rdy[i]) begin
      if (rrs[i] != 0) m_ptr[i] = (m_idx[i] == 0) ? nn[i] - 1 : m_idx[i] - 1;
      w = winner(rq & ~(1 << m_idx[i]), m_ptr[i], nn[i]);
      if (w >= 0) m_idx[i] = w;
      else m_valid[i] = 0;
    end
  endtask

  task automatic check_inst(input int i, input int v, input int idx, input int oh);
    check($sformatf("valid%0d", i), v, m_valid[i]);
    check($sformatf("onehot%0d", i), oh, m_valid[i] != 0 ? (1 << m_idx[i]) : 0);
    if (m_valid[i] != 0) check($sformatf("idx%0d", i), idx, m_idx[i]);
  endtask

  task automatic check_all();
    check_inst(0, int'(if0.gnt_valid), int'(if0.gnt_idx), int'(if0.gnt_onehot));
    check_inst(1, int'(if1.gnt_valid), int'(if1.gnt_idx), int'(if1.gnt_onehot));
    check_inst(2, int'(if2.gnt_valid), int'(if2.gnt_idx), int'(if2.gnt_onehot));
    check("idx_range5", int'(if2.gnt_idx < 3'd5), 1);
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_edge(i);
    #1;
    check_all();
  endtask

  // Assert reset between edges and verify outputs clear before the next edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    check("rst_idx0", int'(if0.gnt_idx), 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  task automatic set_all(input logic [7:0] rq, input logic rdy);
    for (int i = 0; i < 3; i++) begin
      r_req[i] = rq;
      r_rdy[i] = rdy;
    end
  endtask

  task automatic go_idle();
    set_all(8'h00, 1'b1);
    step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    set_all(8'h00, 1'b0);
    model_reset();
    #1;
    check_all();
    #12;
    rst = 1'b0;

    // Reset while granting index 5, then MSB wins on all-ones.
    r_req[0] = 8'b0010_0000;
    step();
    check("t1_idx5", int'(if0.gnt_idx), 5);
    do_reset();
    r_req[0] = 8'hFF;
    step();
    check("t1_idx7", int'(if0.gnt_idx), 7);
    go_idle();

    // Single request: one-edge latency, then drops since it is masked.
    r_req[0] = 8'b0000_1000;
    step();
    check("t2_valid", int'(if0.gnt_valid), 1);
    check("t2_idx", int'(if0.gnt_idx), 3);
    step();
    check("t2_drop", int'(if0.gnt_valid), 0);
    go_idle();

    // Backpressure holds the grant while req changes.
    set_all(8'b0000_0100, 1'b0);
    step();
    r_req[0] = 8'b1000_0000;
    step();
    step();
    check("t3_hold_idx", int'(if0.gnt_idx), 2);
    check("t3_hold_oh", int'(if0.gnt_onehot), 4);
    r_rdy[0] = 1'b1;
    step();
    check("t3_next", int'(if0.gnt_idx), 7);
    go_idle();

    // Fixed priority alternates between two held requests.
    set_all(8'b0000_0110, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t4_idx", int'(if0.gnt_idx), (k % 2 == 0) ? 2 : 1);
    end
    go_idle();

    // Round-robin sweep (N=8) and wrap (N=5) from a fresh pointer.
    do_reset();
    r_req[0] = 8'h00;
    r_req[1] = 8'hFF;
    r_req[2] = 8'b0001_0001;
    for (int i = 0; i < 3; i++) r_rdy[i] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      check("t5_valid", int'(if1.gnt_valid), 1);
      check("t5_idx", int'(if1.gnt_idx), (k == 8) ? 7 : 7 - k);
      if (k < 4) check("t6_idx", int'(if2.gnt_idx), (k % 2 == 0) ? 4 : 0);
    end

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        case ($urandom_range(0, 3))
          0: r_req[i] = 8'h00;
          1: r_req[i] = 8'(1 << $urandom_range(0, 7));
          default: r_req[i] = 8'($urandom);
        endcase
        r_rdy[i] = ($urandom_range(0, 2) != 0);
      end
      if ($urandom_range(0, 99) == 0) do_reset();
      else step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
